float_to_fixed: RTL and testbench
=================================

Name: float_to_fixed

Overview:
Sequential converter from HALF/SINGLE IEEE-754 words to signed two's-complement fixed point "FIXED_II_FF". It is the decode direction of the constant/format encoders: arithmetic blocks produce float results, and this block turns them back into fixed-point values for the fixed datapaths. It uses a valid/ready handshake on both sides and a serial one-bit-per-cycle shifter, which keeps the area small.

Parameters:
IN_PRECISION, "HALF", input format: "HALF" (16b, 5e/10m) or "SINGLE" (32b, 8e/23m)
OUT_PRECISION, "FIXED_08_08", output format: II integer bits incl. sign, FF fraction bits; FRAC parsed from last two chars
IN_BITS, 16, input width (16 for HALF, 32 for SINGLE)
OUT_BITS, 16, output width, must equal II+FF

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input word valid
in_ready  out  1  block can accept a word
in_data  in  IN_BITS  float word
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_data  out  OUT_BITS  signed fixed result
out_ovf  out  1  result saturated (|x| >= 2^(OUT_BITS-1-FRAC), or ±inf)
out_nan  out  1  input was NaN
out_inexact  out  1  nonzero bits were discarded (truncation or underflow)

Behaviour:
- Reset: async, active-low. Drives state IDLE, in_ready=0 during reset and 1 after release, out_valid=0, out_data=0, and all flags 0. Reset asserted mid-conversion aborts the conversion; no output is produced.
- States: IDLE, LOAD, SHIFT, FINISH, HOLD.
- IDLE: in_ready=1. A transfer occurs when in_valid&&in_ready. The block latches sign, exponent, and the mantissa with the hidden bit (0 if exp==0), then goes to LOAD. in_ready=0 in every other state, so only one word is in flight.
- LOAD (1 cycle) classifies the word:
  - exp all-ones, mant!=0 (NaN): result 0, nan=1, go to FINISH.
  - exp all-ones, mant==0 (inf): saturate, ovf=1, go to FINISH.
  - exp==0 (zero/denormal): flush to 0; inexact=1 if mant!=0; go to FINISH.
  - Otherwise compute e = exp - bias and p = e + FRAC, the MSB bit position.
    - p >= OUT_BITS-1: saturate, ovf=1, go to FINISH.
    - p < 0: result 0, inexact=1, go to FINISH.
    - Else s = p - MANT_BITS. Load the magnitude register (width max(OUT_BITS, MANT_BITS+1)) with the mantissa and count=|s|. If count==0 go to FINISH, else go to SHIFT.
- SHIFT: shifts the magnitude one bit per cycle (left if s>0, right if s<0) and decrements count; exits to FINISH when count reaches 1→0. On a right shift, any 1 shifted out sets inexact.
- FINISH (1 cycle): applies the sign (two's-complement negate if sign=1) and registers out_data and the flags.
  - Saturation value: 2^(OUT_BITS-1)-1 for positive, -2^(OUT_BITS-1) for negative.
  - Goes to HOLD with out_valid=1.
- HOLD: out_valid=1. out_data and flags stay stable until out_ready. On out_valid&&out_ready the block returns to IDLE (out_valid=0 next cycle). There is no same-cycle re-accept.
- Latency, accept edge to out_valid: 2+|s| cycles for shifted cases, 2 cycles for special/saturate/zero cases. Bounded by OUT_BITS+MANT_BITS+2.
- Rounding is toward zero: the magnitude is truncated before negation.
- -0.0 yields 0x0, no flags.

Decomposition:
- Shared package precision_pkg holds:
  - format constants (EXP_BITS, MANT_BITS, BIAS per precision)
  - a function parsing FRAC from a "FIXED_II_FF" string, reusable by other fixed-format blocks
  - the state enum type.
- One sub-module, fp_unpack: a combinational splitter/classifier producing sign, unbiased exponent, mantissa with hidden bit, and is_zero/is_denorm/is_inf/is_nan. It is reusable by other float-consuming blocks.

Test Plan:
- HALF→FIXED_08_08, in 0x3C00 (1.0) → out 0x0100, flags 0, out_valid 4 cycles after accept (s=-2).
- in 0xBC00 → 0xFF00; in 0x3800 → 0x0080; in 0x25E9 → 0x0005, inexact=1, latency 10 cycles (s=-8).
- in 0x7C00 → 0x7FFF ovf=1; in 0xFC00 → 0x8000 ovf=1; in 0x5B49 (233.1) → 0x7FFF ovf=1; in 0x7E00 → 0x0000 nan=1; all with latency 2.
- in 0x1400 (2^-10) → 0x0000 inexact=1; in 0x0001 (denormal) → 0x0000 inexact=1; in 0x8000 → 0x0000 no flags.
- Backpressure: hold out_ready=0 for 5 cycles → out_valid/out_data stable, in_ready=0; a second word with in_valid=1 is not accepted until the cycle after the out handshake.
- Assert rst_n=0 during SHIFT → out_valid=0 immediately, in_ready=1 after release, and the next conversion is correct.

Source files
------------

// File: rtl/precision_pkg.sv
// Shared float/fixed format constants, the FIXED_II_FF fraction parser and the
// converter state encoding.
package precision_pkg;

  localparam int HALF_EXP_BITS    = 5;
  localparam int HALF_MANT_BITS   = 10;
  localparam int HALF_BIAS        = 15;
  localparam int SINGLE_EXP_BITS  = 8;
  localparam int SINGLE_MANT_BITS = 23;
  localparam int SINGLE_BIAS      = 127;

  // Format strings are always 11 chars ("FIXED_II_FF"); the low byte is the last char.
  function automatic int frac_of(input logic [87:0] fmt);
    return 10 * (int'(fmt[15:8]) - 48) + (int'(fmt[7:0]) - 48);
  endfunction

  typedef logic [2:0] state_t;
  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_LOAD   = 3'd1;
  localparam state_t S_SHIFT  = 3'd2;
  localparam state_t S_FINISH = 3'd3;
  localparam state_t S_HOLD   = 3'd4;

endpackage

// File: rtl/float_to_fixed_if.sv
// Valid/ready bus of the float-to-fixed converter: float words in, fixed results
// plus status flags out.
interface float_to_fixed_if #(
  parameter int IN_BITS  = 16,
  parameter int OUT_BITS = 16
);
  logic                in_valid;
  logic                in_ready;
  logic [IN_BITS-1:0]  in_data;
  logic                out_valid;
  logic                out_ready;
  logic [OUT_BITS-1:0] out_data;
  logic                out_ovf;
  logic                out_nan;
  logic                out_inexact;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ovf, out_nan, out_inexact
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ovf, out_nan, out_inexact
  );
endinterface

// File: rtl/fp_unpack.sv
// Combinational IEEE-754 field splitter and classifier.
module fp_unpack #(
  parameter int EXP_BITS  = 5,
  parameter int MANT_BITS = 10,
  parameter int BIAS      = 15
) (
  input  logic [EXP_BITS+MANT_BITS:0]  word,
  output logic                         sign,
  output logic signed [EXP_BITS+1:0]   exp_unb,
  output logic [MANT_BITS:0]           mant_h,
  output logic                         is_zero,
  output logic                         is_denorm,
  output logic                         is_inf,
  output logic                         is_nan
);
  localparam logic signed [EXP_BITS+1:0] BIAS_S = BIAS[EXP_BITS+1:0];

  logic [EXP_BITS-1:0]  exp_raw;
  logic [MANT_BITS-1:0] frac;
  logic                 exp_max, exp_zero, frac_nz;

  assign sign     = word[EXP_BITS+MANT_BITS];
  assign exp_raw  = word[EXP_BITS+MANT_BITS-1:MANT_BITS];
  assign frac     = word[MANT_BITS-1:0];
  assign exp_max  = &exp_raw;
  assign exp_zero = ~|exp_raw;
  assign frac_nz  = |frac;

  assign exp_unb   = $signed({2'b00, exp_raw}) - BIAS_S;
  assign mant_h    = {~exp_zero, frac};
  assign is_nan    = exp_max & frac_nz;
  assign is_inf    = exp_max & ~frac_nz;
  assign is_zero   = exp_zero & ~frac_nz;
  assign is_denorm = exp_zero & frac_nz;
endmodule

// File: rtl/float_to_fixed.sv
// Serial HALF/SINGLE float to signed fixed-point converter; one shift per cycle,
// truncating toward zero and saturating on overflow.
module float_to_fixed
  import precision_pkg::*;
#(
  parameter string       IN_PRECISION  = "HALF",
  parameter logic [87:0] OUT_PRECISION = "FIXED_08_08",
  parameter int          IN_BITS       = 16,
  parameter int          OUT_BITS      = 16
) (
  input logic            clk,
  input logic            rst_n,
  float_to_fixed_if.slave io
);
  localparam bit IS_SINGLE = (IN_PRECISION == "SINGLE");
  localparam int EXP_BITS  = IS_SINGLE ? SINGLE_EXP_BITS : HALF_EXP_BITS;
  localparam int MANT_BITS = IS_SINGLE ? SINGLE_MANT_BITS : HALF_MANT_BITS;
  localparam int BIAS      = IS_SINGLE ? SINGLE_BIAS : HALF_BIAS;
  localparam int FRAC      = frac_of(OUT_PRECISION);
  localparam int MAG_W     = (OUT_BITS > MANT_BITS + 1) ? OUT_BITS : MANT_BITS + 1;
  localparam int CNT_W     = $clog2(MAG_W + 1);

  localparam logic [OUT_BITS-1:0] SAT_POS = {1'b0, {(OUT_BITS-1){1'b1}}};
  localparam logic [OUT_BITS-1:0] SAT_NEG = {1'b1, {(OUT_BITS-1){1'b0}}};

  state_t              state_q, state_d;
  logic [IN_BITS-1:0]  word_q, word_d;
  logic [MAG_W-1:0]    mag_q, mag_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                shl_q, shl_d;
  logic                ovf_q, ovf_d, nan_q, nan_d, inexact_q, inexact_d;
  logic                rdy_q, rdy_d;
  logic [OUT_BITS-1:0] out_data_q, out_data_d;
  logic                out_ovf_q, out_ovf_d, out_nan_q, out_nan_d;
  logic                out_inexact_q, out_inexact_d;

  logic                     sign, is_zero, is_denorm, is_inf, is_nan;
  logic signed [EXP_BITS+1:0] exp_unb;
  logic [MANT_BITS:0]       mant_h;
  logic [OUT_BITS-1:0]      mag_o;
  int                       p, s;

  fp_unpack #(.EXP_BITS(EXP_BITS), .MANT_BITS(MANT_BITS), .BIAS(BIAS)) u_unpack (
    .word(word_q), .sign(sign), .exp_unb(exp_unb), .mant_h(mant_h),
    .is_zero(is_zero), .is_denorm(is_denorm), .is_inf(is_inf), .is_nan(is_nan)
  );

  // p is the bit position of the hidden one in the fixed result; s is the shift
  // that moves the mantissa LSB-aligned value there.
  assign p     = int'(exp_unb) + FRAC;
  assign s     = p - MANT_BITS;
  assign mag_o = mag_q[OUT_BITS-1:0];

  always_comb begin
    state_d       = state_q;
    word_d        = word_q;
    mag_d         = mag_q;
    count_d       = count_q;
    shl_d         = shl_q;
    ovf_d         = ovf_q;
    nan_d         = nan_q;
    inexact_d     = inexact_q;
    out_data_d    = out_data_q;
    out_ovf_d     = out_ovf_q;
    out_nan_d     = out_nan_q;
    out_inexact_d = out_inexact_q;
    case (state_q)
      S_IDLE: if (rdy_q && io.in_valid) begin
        word_d    = io.in_data;
        ovf_d     = 1'b0;
        nan_d     = 1'b0;
        inexact_d = 1'b0;
        state_d   = S_LOAD;
      end
      S_LOAD: begin
        mag_d   = '0;
        state_d = S_FINISH;
        if (is_nan) nan_d = 1'b1;
        else if (is_inf) ovf_d = 1'b1;
        else if (is_zero || is_denorm) inexact_d = is_denorm;
        else if (p >= OUT_BITS - 1) ovf_d = 1'b1;
        else if (p < 0) inexact_d = 1'b1;
        else begin
          mag_d   = MAG_W'(mant_h);
          count_d = CNT_W'((s < 0) ? -s : s);
          shl_d   = (s > 0);
          if (s != 0) state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (shl_q) mag_d = mag_q << 1;
        else begin
          mag_d = mag_q >> 1;
          if (mag_q[0]) inexact_d = 1'b1;
        end
        count_d = count_q - 1'b1;
        if (count_q == CNT_W'(1)) state_d = S_FINISH;
      end
      S_FINISH: begin
        if (nan_q) out_data_d = '0;
        else if (ovf_q) out_data_d = sign ? SAT_NEG : SAT_POS;
        else out_data_d = sign ? -mag_o : mag_o;
        out_ovf_d     = ovf_q;
        out_nan_d     = nan_q;
        out_inexact_d = inexact_q;
        state_d       = S_HOLD;
      end
      S_HOLD: if (io.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    rdy_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      word_q        <= '0;
      mag_q         <= '0;
      count_q       <= '0;
      shl_q         <= 1'b0;
      ovf_q         <= 1'b0;
      nan_q         <= 1'b0;
      inexact_q     <= 1'b0;
      rdy_q         <= 1'b0;
      out_data_q    <= '0;
      out_ovf_q     <= 1'b0;
      out_nan_q     <= 1'b0;
      out_inexact_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      word_q        <= word_d;
      mag_q         <= mag_d;
      count_q       <= count_d;
      shl_q         <= shl_d;
      ovf_q         <= ovf_d;
      nan_q         <= nan_d;
      inexact_q     <= inexact_d;
      rdy_q         <= rdy_d;
      out_data_q    <= out_data_d;
      out_ovf_q     <= out_ovf_d;
      out_nan_q     <= out_nan_d;
      out_inexact_q <= out_inexact_d;
    end
  end

  assign io.in_ready    = rdy_q;
  assign io.out_valid   = (state_q == S_HOLD);
  assign io.out_data    = out_data_q;
  assign io.out_ovf     = out_ovf_q;
  assign io.out_nan     = out_nan_q;
  assign io.out_inexact = out_inexact_q;
endmodule

// File: tb/tb_float_to_fixed.sv
// Directed-vector bench for float_to_fixed in HALF -> FIXED_08_08 configuration.
module tb_float_to_fixed;

  typedef struct {
    logic [15:0] din;
    logic [15:0] dout;
    logic        ovf;
    logic        nan;
    logic        inex;
    int          lat;
  } vec_t;

  logic clk;
  logic rst_n;
  int   tests_run = 0;
  int   tests_failed = 0;
  vec_t vecs[$];

  float_to_fixed_if #(.IN_BITS(16), .OUT_BITS(16)) bus ();

  float_to_fixed #(
    .IN_PRECISION("HALF"), .OUT_PRECISION("FIXED_08_08"), .IN_BITS(16), .OUT_BITS(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .io(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Offers a word, waits for acceptance, then counts cycles until out_valid.
  task automatic applyStimulus(input logic [15:0] din, output int lat);
    int n;
    n = 0;
    bus.in_data  = din;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("accept_wait_bound", 32'(n < 20), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic releaseOutput();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checkOutput("out_valid_drop", 32'(bus.out_valid), 32'd0);
  endtask

  task automatic runVector(input vec_t v);
    int lat;
    applyStimulus(v.din, lat);
    checkOutput($sformatf("data_%h", v.din), 32'(bus.out_data), 32'(v.dout));
    checkOutput($sformatf("ovf_%h", v.din), 32'(bus.out_ovf), 32'(v.ovf));
    checkOutput($sformatf("nan_%h", v.din), 32'(bus.out_nan), 32'(v.nan));
    checkOutput($sformatf("inexact_%h", v.din), 32'(bus.out_inexact), 32'(v.inex));
    checkOutput($sformatf("latency_%h", v.din), 32'(lat), 32'(v.lat));
    releaseOutput();
  endtask

  initial begin
    int lat;
    int seen;
    vecs.push_back('{16'h3C00, 16'h0100, 1'b0, 1'b0, 1'b0, 4});
    vecs.push_back('{16'hBC00, 16'hFF00, 1'b0, 1'b0, 1'b0, 4});
    vecs.push_back('{16'h3800, 16'h0080, 1'b0, 1'b0, 1'b0, 5});
    vecs.push_back('{16'h25E9, 16'h0005, 1'b0, 1'b0, 1'b1, 10});
    vecs.push_back('{16'hA5E9, 16'hFFFB, 1'b0, 1'b0, 1'b1, 10});
    vecs.push_back('{16'h7C00, 16'h7FFF, 1'b1, 1'b0, 1'b0, 2});
    vecs.push_back('{16'hFC00, 16'h8000, 1'b1, 1'b0, 1'b0, 2});
    vecs.push_back('{16'h5B49, 16'h7FFF, 1'b1, 1'b0, 1'b0, 2});
    vecs.push_back('{16'h7E00, 16'h0000, 1'b0, 1'b1, 1'b0, 2});
    vecs.push_back('{16'h1400, 16'h0000, 1'b0, 1'b0, 1'b1, 2});
    vecs.push_back('{16'h0001, 16'h0000, 1'b0, 1'b0, 1'b1, 2});
    vecs.push_back('{16'h8000, 16'h0000, 1'b0, 1'b0, 1'b0, 2});
    vecs.push_back('{16'h5700, 16'h7000, 1'b0, 1'b0, 1'b0, 6});
    vecs.push_back('{16'hD700, 16'h9000, 1'b0, 1'b0, 1'b0, 6});
    vecs.push_back('{16'h4400, 16'h0400, 1'b0, 1'b0, 1'b0, 2});

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset_out_data", 32'(bus.out_data), 32'd0);
    checkOutput("reset_flags", 32'({bus.out_ovf, bus.out_nan, bus.out_inexact}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("release_in_ready", 32'(bus.in_ready), 32'd1);

    foreach (vecs[i]) runVector(vecs[i]);

    // Backpressure: result must hold while a second word waits at the input.
    applyStimulus(16'h3C00, lat);
    checkOutput("bp_latency", 32'(lat), 32'd4);
    bus.in_data  = 16'h3800;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("bp_valid_%0d", c), 32'(bus.out_valid), 32'd1);
      checkOutput($sformatf("bp_data_%0d", c), 32'(bus.out_data), 32'h0100);
      checkOutput($sformatf("bp_in_ready_%0d", c), 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checkOutput("bp_out_valid_drop", 32'(bus.out_valid), 32'd0);
    checkOutput("bp_in_ready_after", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checkOutput("bp_second_accepted", 32'(bus.in_ready), 32'd0);
    lat = 0;
    while (!bus.out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("bp_second_latency", 32'(lat), 32'd5);
    checkOutput("bp_second_data", 32'(bus.out_data), 32'h0080);
    releaseOutput();

    // Reset in the middle of a long right shift aborts the conversion.
    bus.in_data  = 16'h25E9;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("abort_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("abort_release_in_ready", 32'(bus.in_ready), 32'd1);
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    checkOutput("abort_no_output", 32'(seen), 32'd0);
    runVector(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
